// File: rtl/reg_dump_uart.sv
// rtl/reg_dump_uart.sv - dumps the 32-entry core register file over an 8N1 UART
// Frame: header 0xA5, then x0..x31 MSB byte first; one FETCH cycle precedes each register.
module reg_dump_uart #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    tx_byte;
  logic [31:0]   shift_reg;
  logic          header;
  logic          last_reg;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_addr  <= 5'd0;
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 2'd0;
      tx_byte   <= 8'h00;
      shift_reg <= 32'h0;
      header    <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= START;
            busy     <= 1'b1;
            tx       <= 1'b0;
            tx_byte  <= 8'hA5;
            header   <= 1'b1;
            last_reg <= 1'b0;
            reg_addr <= 5'd0;
            baud_cnt <= '0;
          end
        end
        FETCH: begin
          // Advance the address now so it has a whole register's worth of bytes to settle.
          tx_byte   <= reg_data[31:24];
          shift_reg <= {reg_data[23:0], 8'h00};
          byte_cnt  <= 2'd0;
          last_reg  <= (reg_addr == 5'd31);
          if (reg_addr != 5'd31) reg_addr <= reg_addr + 5'd1;
          tx        <= 1'b0;
          baud_cnt  <= '0;
          state     <= START;
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx       <= tx_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= tx_byte[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (header) begin
              header <= 1'b0;
              state  <= FETCH;
            end else if (byte_cnt == 2'd3) begin
              if (last_reg) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= FETCH;
              end
            end else begin
              byte_cnt  <= byte_cnt + 2'd1;
              tx_byte   <= shift_reg[31:24];
              shift_reg <= {shift_reg[23:0], 8'h00};
              tx        <= 1'b0;
              state     <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
